cskipa_sub_9bit: RTL and testbench

//  Block-serial 9-bit carry-skip subtractor: diff = i_sub_term1 - i_sub_term2 (two's complement).

---
 rtl/cskipa_pkg.sv | 9 +
 rtl/cskipa_blk_sub.sv | 33 +++
 rtl/cskipa_sub_9bit.sv | 118 +++++++++++
 tb/tb_cskipa_sub_9bit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cskipa_pkg.sv
// Shared constants and FSM state type for the block-serial carry-skip subtractor.
package cskipa_pkg;
  localparam int WIDTH = 9;
  localparam int BLOCK = 4;
  localparam int NBLK  = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int BLK_W = $clog2(NBLK);

  typedef enum logic [1:0] {IDLE, CALC, DONE} cskipa_state_t;
endpackage

// File: rtl/cskipa_blk_sub.sv
// One carry-skip block: ripple sum over the valid bits, block propagate, skip mux on carry out.
module cskipa_blk_sub
  import cskipa_pkg::*;
(
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] nb,
  input  logic [BLOCK-1:0] mask,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             prop,
  output logic             cout_skip
);
  logic [BLOCK-1:0] p, g;
  logic             c;

  assign p = a ^ nb;
  assign g = a & nb;

  always_comb begin
    c    = cin;
    prop = 1'b1;
    sum  = '0;
    // masked-off bits are transparent: no sum, carry and propagate untouched
    for (int j = 0; j < BLOCK; j++) begin
      if (mask[j]) begin
        sum[j] = p[j] ^ c;
        c      = g[j] | (p[j] & c);
        prop   = prop & p[j];
      end
    end
    cout_skip = prop ? cin : c;
  end
endmodule

// File: rtl/cskipa_sub_9bit.sv
// Block-serial 9-bit carry-skip subtractor (diff = term1 - term2), one block per clock.
// Optional signed-overflow output o_ovf enabled by defining CSKIPA_SUB_OVF_EN.
module cskipa_sub_9bit
  import cskipa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CSKIPA_SUB_OVF_EN
  ,
  output logic             o_ovf
`endif
);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NBLK - 1);

  cskipa_state_t    state, state_n;
  logic [BLK_W-1:0] blk;
  logic             carry;
  logic [WIDTH-1:0] a_q, nb_q, diff_n;
  logic [BLOCK-1:0] a_blk, nb_blk, mask, sum;
  logic             prop, cout_skip;

  always_comb begin
    a_blk  = '0;
    nb_blk = '0;
    mask   = '0;
    diff_n = diff;
    for (int i = 0; i < WIDTH; i++) begin
      if (blk == BLK_W'(i / BLOCK)) begin
        a_blk[i % BLOCK]  = a_q[i];
        nb_blk[i % BLOCK] = nb_q[i];
        mask[i % BLOCK]   = 1'b1;
        diff_n[i]         = sum[i % BLOCK];
      end
    end
  end

  cskipa_blk_sub u_blk (
    .a         (a_blk),
    .nb        (nb_blk),
    .mask      (mask),
    .cin       (carry),
    .sum       (sum),
    .prop      (prop),
    .cout_skip (cout_skip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_n = CALC;
      end
      CALC: if (blk == LAST_BLK) state_n = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      nb_q  <= '0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef CSKIPA_SUB_OVF_EN
      o_ovf <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          // subtract as a + ~b + 1: the +1 enters as the initial carry
          a_q   <= i_sub_term1;
          nb_q  <= ~i_sub_term2;
          carry <= 1'b1;
          blk   <= '0;
        end
        CALC: begin
          diff  <= diff_n;
          carry <= cout_skip;
          if (blk == LAST_BLK) begin
            bout <= ~cout_skip;
`ifdef CSKIPA_SUB_OVF_EN
            // term2 sign is ~nb, so "signs differ" is a == nb
            o_ovf <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (diff_n[WIDTH-1] != a_q[WIDTH-1]);
`endif
          end else begin
            blk <= blk + BLK_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  logic unused;
  assign unused = prop;
endmodule

// File: tb/tb_cskipa_sub_9bit.sv
// Directed table-driven bench for cskipa_sub_9bit, plus backpressure and reset-abort sequences.
module tb_cskipa_sub_9bit;
  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid, o_ready, o_valid, i_ready, bout;
  logic [8:0] i_sub_term1, i_sub_term2, diff;
  logic       ovf;
`ifdef CSKIPA_SUB_OVF_EN
  logic       o_ovf;
  assign ovf = o_ovf;
`else
  assign ovf = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cskipa_sub_9bit dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sub_term1 (i_sub_term1),
    .i_sub_term2 (i_sub_term2),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .diff        (diff),
    .bout        (bout)
`ifdef CSKIPA_SUB_OVF_EN
    ,
    .o_ovf       (o_ovf)
`endif
  );

  typedef struct {
    logic [8:0] t1, t2, exp_diff;
    logic       exp_bout, exp_ovf;
    int         hold;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int lat;
    chk("ready_before", int'(o_ready), 1);
    @(negedge clk);
    i_sub_term1 = v.t1;
    i_sub_term2 = v.t2;
    i_valid     = 1'b1;
    i_ready     = 1'b0;
    @(posedge clk); #1;
    i_valid     = 1'b0;
    i_sub_term1 = ~v.t1;
    i_sub_term2 = v.t1;
    lat = 0;
    while (!o_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 3);
    chk("diff", int'(diff), int'(v.exp_diff));
    chk("bout", int'(bout), int'(v.exp_bout));
`ifdef CSKIPA_SUB_OVF_EN
    chk("ovf", int'(ovf), int'(v.exp_ovf));
`endif
    for (int k = 0; k < v.hold; k++) begin
      @(negedge clk);
      i_valid = k[0];
      @(posedge clk); #1;
      chk("hold_valid", int'(o_valid), 1);
      chk("hold_ready", int'(o_ready), 0);
      chk("hold_diff", int'(diff), int'(v.exp_diff));
      chk("hold_bout", int'(bout), int'(v.exp_bout));
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk("release_valid", int'(o_valid), 0);
    chk("release_ready", int'(o_ready), 1);
    chk("kept_diff", int'(diff), int'(v.exp_diff));
  endtask

  initial begin
    vecs[0]  = '{9'd300,  9'd45,   9'd255,  1'b0, 1'b1, 0};
    vecs[1]  = '{9'd5,    9'd6,    9'd511,  1'b1, 1'b0, 0};
    vecs[2]  = '{9'd0,    9'd0,    9'd0,    1'b0, 1'b0, 0};
    vecs[3]  = '{9'h0FF,  9'h000,  9'd255,  1'b0, 1'b0, 0};
    vecs[4]  = '{9'h100,  9'h001,  9'd255,  1'b0, 1'b1, 6};
    vecs[5]  = '{9'h0FF,  9'h1FF,  9'd256,  1'b1, 1'b1, 0};
    vecs[6]  = '{9'd3,    9'd5,    9'd510,  1'b1, 1'b0, 0};
    vecs[7]  = '{9'h1FF,  9'h001,  9'd510,  1'b0, 1'b0, 0};
    vecs[8]  = '{9'h0FF,  9'h100,  9'd511,  1'b1, 1'b1, 0};
    vecs[9]  = '{9'h155,  9'h0AA,  9'h0AB,  1'b0, 1'b1, 0};
    vecs[10] = '{9'h0AA,  9'h155,  9'h155,  1'b1, 1'b1, 2};
    vecs[11] = '{9'd7,    9'd3,    9'd4,    1'b0, 1'b0, 0};

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_sub_term1 = '0; i_sub_term2 = '0;
    #22;
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_bout", int'(bout), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk); rst = 1'b0;

    for (int n = 0; n < 11; n++) run_txn(vecs[n]);

    // reset abort between the first and second CALC edges
    @(negedge clk);
    i_sub_term1 = 9'd100; i_sub_term2 = 9'd1; i_valid = 1'b1;
    @(posedge clk); #1; i_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_valid", int'(o_valid), 0);
    chk("abort_ready", int'(o_ready), 1);
    chk("abort_diff", int'(diff), 0);
    chk("abort_bout", int'(bout), 0);
    chk("abort_ovf", int'(ovf), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_still_idle", int'(o_valid), 0);
    @(negedge clk); rst = 1'b0;
    run_txn(vecs[11]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
